// File: rtl/traffic_light.sv
// Two-road traffic light controller with yellow-phase countdown on a two-digit 7-segment display.
// Define TRAFFIC_LIGHT_SIM_FAST_EN to bypass the one-second divider (one tick per clock).
module traffic_light #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned YELLOW_SEC = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  output logic [7:0] led_7_segment_1,
  output logic [7:0] led_7_segment_2,
  output logic       led_7_segment_1_ena,
  output logic       led_7_segment_2_ena,
  output logic [2:0] La,
  output logic [2:0] Lb
);

  localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [7:0] SegOff     = 8'hFF;

  typedef enum logic [1:0] {StAGreen, StAYellow, StBGreen, StBYellow} state_e;

  state_e          state_q, state_d;
  logic [6:0]      count_q, count_d;
  logic [DivW-1:0] div_q, div_d;
  logic            div_wrap, tick;

  logic [2:0] la_q, la_d, lb_q, lb_d;
  logic [7:0] seg1_q, seg1_d, seg2_q, seg2_d;
  logic       ena_q, ena_d;
  logic [6:0] tens, units;

  function automatic logic [7:0] seg_of(input logic [6:0] digit);
    logic [7:0] seg;
    unique case (digit)
      7'd0:    seg = 8'hC0;
      7'd1:    seg = 8'hF9;
      7'd2:    seg = 8'hA4;
      7'd3:    seg = 8'hB0;
      7'd4:    seg = 8'h99;
      7'd5:    seg = 8'h92;
      7'd6:    seg = 8'h82;
      7'd7:    seg = 8'hF8;
      7'd8:    seg = 8'h80;
      7'd9:    seg = 8'h90;
      default: seg = SegOff;
    endcase
    return seg;
  endfunction

  assign div_wrap = (div_q == DivW'(CLK_HZ - 1));

`ifdef TRAFFIC_LIGHT_SIM_FAST_EN
  assign tick = 1'b1;
`else
  assign tick = div_wrap;
`endif

  // Next state; the divider restarts on yellow entry so the first second is full length.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_wrap ? '0 : div_q + 1'b1;
    unique case (state_q)
      StAGreen: begin
        if (!Ta) begin
          state_d = StAYellow;
          count_d = 7'(YELLOW_SEC);
          div_d   = '0;
        end
      end
      StAYellow: begin
        if (tick) begin
          count_d = count_q - 7'd1;
          if (count_q == 7'd1) state_d = StBGreen;
        end
      end
      StBGreen: begin
        if (!Tb) begin
          state_d = StBYellow;
          count_d = 7'(YELLOW_SEC);
          div_d   = '0;
        end
      end
      StBYellow: begin
        if (tick) begin
          count_d = count_q - 7'd1;
          if (count_q == 7'd1) state_d = StAGreen;
        end
      end
      default: state_d = StAGreen;
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    la_d   = LampRed;
    lb_d   = LampRed;
    seg1_d = SegOff;
    seg2_d = SegOff;
    ena_d  = 1'b0;
    tens   = count_d / 7'd10;
    units  = count_d % 7'd10;
    unique case (state_d)
      StAGreen:  la_d = LampGreen;
      StAYellow: la_d = LampYellow;
      StBGreen:  lb_d = LampGreen;
      StBYellow: lb_d = LampYellow;
      default:   la_d = LampGreen;
    endcase
    if (state_d == StAYellow || state_d == StBYellow) begin
      seg1_d = seg_of(tens);
      seg2_d = seg_of(units);
      ena_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StAGreen;
      count_q <= '0;
      div_q   <= '0;
      la_q    <= LampGreen;
      lb_q    <= LampRed;
      seg1_q  <= SegOff;
      seg2_q  <= SegOff;
      ena_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
      seg1_q  <= seg1_d;
      seg2_q  <= seg2_d;
      ena_q   <= ena_d;
    end
  end

  assign La                  = la_q;
  assign Lb                  = lb_q;
  assign led_7_segment_1     = seg1_q;
  assign led_7_segment_2     = seg2_q;
  assign led_7_segment_1_ena = ena_q;
  assign led_7_segment_2_ena = ena_q;

endmodule

// File: tb/tb_traffic_light.sv
// Randomized bench for traffic_light against a phase/elapsed-cycle model, plus directed pins.
module tb_traffic_light;

  localparam int Y = 5;
`ifdef TRAFFIC_LIGHT_SIM_FAST_EN
  localparam int P    = 1;
  localparam int YLEN = 5;
`else
  localparam int P    = 4;
  localparam int YLEN = 20;
`endif

  localparam logic [7:0] SEGTAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       Ta, Tb;
  logic [7:0] seg1, seg2;
  logic       ena1, ena2;
  logic [2:0] La, Lb;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model: phase 0=A green, 1=A yellow, 2=B green, 3=B yellow; el = cycles spent in yellow.
  int m_ph, m_el;

  traffic_light #(.CLK_HZ(4), .YELLOW_SEC(Y)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .Ta                  (Ta),
    .Tb                  (Tb),
    .led_7_segment_1     (seg1),
    .led_7_segment_2     (seg2),
    .led_7_segment_1_ena (ena1),
    .led_7_segment_2_ena (ena2),
    .La                  (La),
    .Lb                  (Lb)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph <= 0;
      m_el <= 0;
    end else begin
      case (m_ph)
        0: if (!Ta) begin m_ph <= 1; m_el <= 0; end
        2: if (!Tb) begin m_ph <= 3; m_el <= 0; end
        default: begin
          if (m_el + 1 == Y * P) m_ph <= (m_ph + 1) % 4;
          else m_el <= m_el + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en && reset_n) begin
      int val;
      bit yel;
      yel = (m_ph == 1 || m_ph == 3);
      val = Y - m_el / P;
      check("La", La, m_ph == 0 ? 3'b001 : (m_ph == 1 ? 3'b010 : 3'b100));
      check("Lb", Lb, m_ph == 2 ? 3'b001 : (m_ph == 3 ? 3'b010 : 3'b100));
      check("seg1", seg1, yel ? SEGTAB[val / 10] : 8'hFF);
      check("seg2", seg2, yel ? SEGTAB[val % 10] : 8'hFF);
      check("ena1", ena1, yel);
      check("ena2", ena2, yel);
    end
  end

  task automatic wait_la(input logic [2:0] want, input int budget);
    int n = 0;
    while (La !== want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_La", La, want);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_La"}, La, 3'b001);
    check({tag, "_Lb"}, Lb, 3'b100);
    check({tag, "_seg"}, {seg1, seg2}, 16'hFFFF);
    check({tag, "_ena"}, {ena1, ena2}, 2'b00);
  endtask

  initial begin
    int n;
    Ta = 1'b1;
    Tb = 1'b1;
    reset_n = 1'b0;
    #45;
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_S0", La, 3'b001);

    // A-to-B handover with pinned first yellow cycle
    Ta = 1'b0;
    @(negedge clk);
    Ta = 1'b1;
    check("y1_La", La, 3'b010);
    check("y1_Lb", Lb, 3'b100);
    check("y1_seg", {seg1, seg2}, 16'hC092);
    check("y1_ena", {ena1, ena2}, 2'b11);
    n = 1;
    while (La === 3'b010 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("yellow_len", n - 1, YLEN);
    check("after_y_Lb", Lb, 3'b001);

    // Ta ignored in B green
    Ta = 1'b0;
    repeat (20) @(negedge clk);
    check("mask_Lb", Lb, 3'b001);
    Ta = 1'b1;
    Tb = 1'b0;
    @(negedge clk);
    Tb = 1'b1;
    check("b_yel_Lb", Lb, 3'b010);
    check("b_yel_seg", {seg1, seg2}, 16'hC092);
    wait_la(3'b001, 200);
    repeat (3) @(negedge clk);
    check("back_S0", La, 3'b001);

    for (int i = 0; i < 2000; i++) begin
      Ta = ($urandom_range(0, 3) != 0);
      Tb = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of A yellow
    Ta = 1'b0;
    Tb = 1'b1;
    wait_la(3'b010, 200);
    Ta = 1'b1;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #2;
    check_reset_outputs("async");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      Ta = ($urandom_range(0, 2) != 0);
      Tb = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Two-road intersection controller (road A, road B) with Moore FSM and traffic sensors Ta/Tb.
- A road stays green while its sensor reports traffic, then goes through a timed yellow phase.
- A two-digit 7-segment display shows the yellow-phase countdown in seconds.
- Top-level board block: sensors in, lamp drives and segment drives out.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per one-second tick.
- YELLOW_SEC, 5, yellow phase length in seconds; legal range 1..99.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- Ta  in  1  road A traffic sensor; 1 = traffic present; synchronous input.
- Tb  in  1  road B traffic sensor; 1 = traffic present; synchronous input.
- led_7_segment_1  out  8  tens digit segments, active-low, {dp,g,f,e,d,c,b,a}.
- led_7_segment_2  out  8  units digit segments, same encoding.
- led_7_segment_1_ena  out  1  tens digit enable, active-high.
- led_7_segment_2_ena  out  1  units digit enable, active-high.
- La  out  3  road A lamps {red,yellow,green}, one-hot.
- Lb  out  3  road B lamps {red,yellow,green}, one-hot.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Lamp encoding: green = 3'b001, yellow = 3'b010, red = 3'b100. Exactly one bit set at all times.
- States and outputs:
  - S0: La = green, Lb = red.
  - S1: La = yellow, Lb = red.
  - S2: La = red, Lb = green.
  - S3: La = red, Lb = yellow.
- Transitions:
  - S0 -> S1 on the first rising edge where Ta == 0; S0 holds while Ta == 1.
  - S1 -> S2 when the countdown expires. Ta and Tb are ignored in S1.
  - S2 -> S3 on the first rising edge where Tb == 0; S2 holds while Tb == 1.
  - S3 -> S0 when the countdown expires. Ta and Tb are ignored in S3.
  - Ta is ignored in S2; Tb is ignored in S0.
- Timing: outputs are registered, decoded from the state register. Lamps change in the same cycle the state register updates, i.e. one clock after the sampling edge.
- Tick divider:
  - Counts 0..CLK_HZ-1 and emits a one-cycle tick at CLK_HZ-1.
  - Cleared to 0 on every entry into S1 or S3, so the first second of each yellow phase is a full second.
- Countdown register, 7 bits:
  - Loaded with YELLOW_SEC on entry to S1/S3.
  - Decrements on each tick.
  - When the value is 1 and a tick occurs, the FSM leaves the yellow state and the countdown goes to 0.
  - Yellow therefore lasts exactly YELLOW_SEC*CLK_HZ cycles.
- Display in S1/S3:
  - Both enables = 1.
  - led_7_segment_1 = tens digit of the countdown; led_7_segment_2 = units digit.
  - Tens digit 0 is still shown as "0", no blanking.
- Display in S0/S2: both enables = 0 and both segment buses = 8'hFF (all off).
- Segment codes (dp always off, bit7 = 1): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Reset values: state S0, La = 001, Lb = 100, led_7_segment_1/2 = FF, both ena = 0, divider = 0, countdown = 0.
- Reset asserted mid-phase (any state) returns to S0 immediately, without waiting for a clock edge. Operation resumes on the first edge after reset_n = 1.
- Simultaneous events:
  - Ta and Tb both 0 in S0: only Ta acts.
  - Sensor toggles during yellow have no effect and are not latched.

Optional Feature:
- Macro TRAFFIC_LIGHT_SIM_FAST_EN.
- Defined: the tick divider is bypassed and a tick occurs every clock cycle (CLK_HZ ignored). Yellow lasts YELLOW_SEC cycles. The display counts down once per cycle.
- Not defined: the divider operates as specified in Behaviour.

Test Plan (TRAFFIC_LIGHT_SIM_FAST_EN defined, YELLOW_SEC = 5, 20 ns clock):
- Reset hold: reset_n = 0 for 50 ns with Ta = Tb = 1 -> La = 001, Lb = 100, led = FF/FF, ena = 0/0. Release, wait 100 ns -> unchanged S0.
- A-to-B handover: drive Ta = 0 in S0.
  - Next cycle: La = 010, Lb = 100, led1 = C0, led2 = 92, ena = 1/1.
  - Then led2 steps through 99, B0, A4, F9.
  - 5 cycles after entry: La = 100, Lb = 001, led = FF/FF.
- Sensor masking: Ta = 0 held in S2 for 20 cycles with Tb = 1 -> stays S2.
- B-to-A handover: Tb = 0 in S2 -> S3 with Lb = 010, countdown 05..01 -> S0 after 5 cycles. Ta = 1 at that point keeps S0.
- Async reset in yellow: assert reset_n = 0 mid-S1 between clock edges -> outputs at reset values before the next edge.
- Divider (macro undefined, CLK_HZ = 4): Ta = 0 -> yellow lasts exactly 20 cycles; each digit is held 4 cycles.
